mver_enc: RTL and testbench

MVER_ENC -- requirements
Module: mver_enc

---
 rtl/mver_enc.sv | 153 +++++++++++++++
 tb/tb_mver_enc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mver_enc.sv
// mver_enc: one-hot to binary encoder with a 2-entry result FIFO and a
// saturating count of illegal code words.
// Optional feature macro: MVER_ENC_PRIO_EN -- when defined, multi-hot words
// encode to their highest set bit instead of being flagged as errors.
//
// FIFO occupancy FSM:
//   state   | meaning
//   S_EMPTY | no result buffered, outputs forced to zero
//   S_ONE   | one result buffered in slot 0 (head)
//   S_FULL  | two results buffered, slot 0 head, slot 1 tail; input stalled
module mver_enc #(
  parameter int CNT_W = 8
) (
  input  logic             ver_clk,
  input  logic             ver_rst,
  input  logic [7:0]       ver_in,
  input  logic             ver_in_valid,
  output logic             ver_in_ready,
  output logic [2:0]       ver_out,
  output logic             ver_out_valid,
  input  logic             ver_out_ready,
  output logic             ver_err,
  output logic [CNT_W-1:0] ver_err_cnt,
  input  logic             ver_err_clr
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [3:0]       r_slot0;
  logic [3:0]       r_slot1;
  logic [CNT_W-1:0] r_err_cnt;

  logic [3:0]       w_ones;
  logic [2:0]       w_hi;
  logic [2:0]       w_enc_idx;
  logic             w_enc_err;
  logic             w_push;
  logic             w_pop;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_shift;
  logic             w_out_valid;

  // Count set bits and find the highest one; a legal word has exactly one.
  always_comb begin
    w_ones = 4'd0;
    w_hi   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ver_in[i]) begin
        w_ones = w_ones + 4'd1;
        w_hi   = 3'(i);
      end
    end
  end

  // Map the bit statistics onto {index, err}; only multi-hot handling varies.
  always_comb begin
`ifdef MVER_ENC_PRIO_EN
    w_enc_err = (w_ones == 4'd0);
`else
    w_enc_err = (w_ones != 4'd1);
`endif
    w_enc_idx = w_enc_err ? 3'd0 : w_hi;
  end

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_push      = ver_in_valid & r_in_ready;
  assign w_pop       = w_out_valid & ver_out_ready;

  // Occupancy state register.
  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) r_state <= S_EMPTY;
    else         r_state <= w_state_nxt;
  end

  // Next occupancy and slot write controls for push/pop combinations.
  always_comb begin
    w_state_nxt = r_state;
    w_wr0       = 1'b0;
    w_wr1       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_wr0       = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_wr0 = 1'b1;
        end else if (w_push) begin
          w_wr1       = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // Ready is low while full, so only a pop can happen here.
        if (w_pop) begin
          w_shift     = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Registered ready: low through reset, then tracks "not full" one edge late
  // so it never depends on ver_out_ready in the same cycle.
  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) r_in_ready <= 1'b0;
    else         r_in_ready <= (w_state_nxt != S_FULL);
  end

  // Result slots; slot 0 is always the head presented on the outputs.
  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) begin
      r_slot0 <= 4'd0;
      r_slot1 <= 4'd0;
    end else begin
      if (w_wr0)        r_slot0 <= {w_enc_idx, w_enc_err};
      else if (w_shift) r_slot0 <= r_slot1;
      if (w_wr1)        r_slot1 <= {w_enc_idx, w_enc_err};
    end
  end

  // Saturating illegal-word counter; clear wins over an increment.
  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) begin
      r_err_cnt <= '0;
    end else if (ver_err_clr) begin
      r_err_cnt <= '0;
    end else if (w_push && w_enc_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign ver_in_ready  = r_in_ready;
  assign ver_out_valid = w_out_valid;
  assign ver_out       = w_out_valid ? r_slot0[3:1] : 3'd0;
  assign ver_err       = w_out_valid ? r_slot0[0]   : 1'b0;
  assign ver_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mver_enc.sv
// Bench for mver_enc: scoreboard of expected {index, err} results, plus a
// second instance with a 2-bit counter for saturation.
module tb_mver_enc;

  logic       ver_clk = 1'b0;
  logic       ver_rst = 1'b0;
  logic [7:0] ver_in = 8'd0;
  logic       ver_in_valid = 1'b0;
  logic       ver_in_ready;
  logic [2:0] ver_out;
  logic       ver_out_valid;
  logic       ver_out_ready = 1'b0;
  logic       ver_err;
  logic [7:0] ver_err_cnt;
  logic       ver_err_clr = 1'b0;

  logic [7:0] d2_in = 8'd0;
  logic       d2_in_valid = 1'b0;
  logic       d2_in_ready;
  logic [2:0] d2_out;
  logic       d2_out_valid;
  logic       d2_out_ready = 1'b1;
  logic       d2_err;
  logic [1:0] d2_err_cnt;
  logic       d2_err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [3:0] q[$];
  int         exp_cnt = 0;
  logic       exp_ready = 1'b0;

  always #5 ver_clk = ~ver_clk;

  mver_enc #(.CNT_W(8)) dut (
    .ver_clk(ver_clk), .ver_rst(ver_rst), .ver_in(ver_in),
    .ver_in_valid(ver_in_valid), .ver_in_ready(ver_in_ready),
    .ver_out(ver_out), .ver_out_valid(ver_out_valid),
    .ver_out_ready(ver_out_ready), .ver_err(ver_err),
    .ver_err_cnt(ver_err_cnt), .ver_err_clr(ver_err_clr)
  );

  mver_enc #(.CNT_W(2)) dut2 (
    .ver_clk(ver_clk), .ver_rst(ver_rst), .ver_in(d2_in),
    .ver_in_valid(d2_in_valid), .ver_in_ready(d2_in_ready),
    .ver_out(d2_out), .ver_out_valid(d2_out_valid),
    .ver_out_ready(d2_out_ready), .ver_err(d2_err),
    .ver_err_cnt(d2_err_cnt), .ver_err_clr(d2_err_clr)
  );

  // Reference encoding: {index, err}.
  function automatic logic [3:0] model(input logic [7:0] w);
    int n;
    int hi;
    n  = $countones(w);
    hi = 0;
    for (int i = 7; i >= 0; i--) begin
      if (w[i]) begin
        hi = i;
        break;
      end
    end
    if (n == 1) return {3'(hi), 1'b0};
`ifdef MVER_ENC_PRIO_EN
    if (n > 1) return {3'(hi), 1'b0};
`endif
    return 4'b0001;
  endfunction

  // One clock: compare outputs against the scoreboard just before the rising
  // edge, then account for the transfers that edge performs.
  task automatic tick();
    logic       fin;
    logic       fout;
    logic [3:0] e;
    #1;
    checks++;
    if (ver_out_valid !== (q.size() != 0)) begin
      failures++;
      $display("FAIL out_valid got=%0b exp=%0b", ver_out_valid, (q.size() != 0));
    end
    if (q.size() != 0 && ver_out_valid === 1'b1) begin
      checks++;
      if ({ver_out, ver_err} !== q[0]) begin
        failures++;
        $display("FAIL head got=%0d/%0b exp=%0d/%0b", ver_out, ver_err, q[0][3:1], q[0][0]);
      end
    end else if (ver_out_valid === 1'b0) begin
      checks++;
      if ({ver_out, ver_err} !== 4'd0) begin
        failures++;
        $display("FAIL idle_zero got=%0d/%0b exp=0/0", ver_out, ver_err);
      end
    end
    checks++;
    if (ver_in_ready !== exp_ready) begin
      failures++;
      $display("FAIL in_ready got=%0b exp=%0b", ver_in_ready, exp_ready);
    end
    checks++;
    if (ver_err_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL err_cnt got=%0d exp=%0d", ver_err_cnt, exp_cnt);
    end
    fin  = ver_in_valid && ver_in_ready;
    fout = ver_out_valid && ver_out_ready;
    if (ver_rst) begin
      q.delete();
      exp_cnt   = 0;
      exp_ready = 1'b0;
    end else begin
      if (fout && q.size() != 0) void'(q.pop_front());
      e = model(ver_in);
      if (fin) q.push_back(e);
      if (ver_err_clr) exp_cnt = 0;
      else if (fin && e[0] && exp_cnt != 255) exp_cnt++;
      exp_ready = (q.size() < 2);
    end
    @(negedge ver_clk);
  endtask

  task automatic test_reset();
    #1 ver_rst = 1'b1;
    #1;
    checks++;
    if ({ver_out_valid, ver_out, ver_err, ver_in_ready} !== 6'd0 || ver_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_async got=%0b%0d%0b%0b cnt=%0d exp=0", ver_out_valid, ver_out, ver_err, ver_in_ready, ver_err_cnt);
    end
    @(negedge ver_clk);
    tick();
    tick();
    ver_rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_onehot();
    ver_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ver_in       = 8'd1 << i;
      ver_in_valid = 1'b1;
      tick();
    end
    ver_in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    ver_out_ready = 1'b0;
    ver_in_valid  = 1'b1;
    ver_in        = 8'h10;
    tick();
    ver_in        = 8'h80;
    tick();
    ver_in_valid  = 1'b0;
    #1;
    checks++;
    if (ver_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got=%0b exp=0", ver_in_ready);
    end
    tick();
    tick();
    ver_out_ready = 1'b1;
    ver_in_valid  = 1'b1;
    ver_in        = 8'h01;
    tick();
    #1;
    checks++;
    if (ver_in_ready !== 1'b1 || ver_out !== 3'd7) begin
      failures++;
      $display("FAIL after_pop got=%0b/%0d exp=1/7", ver_in_ready, ver_out);
    end
    ver_in_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_errors();
    ver_out_ready = 1'b1;
    ver_in        = 8'h00;
    ver_in_valid  = 1'b1;
    tick();
    ver_in_valid  = 1'b0;
    #1;
    checks++;
    if (ver_err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL zero_cnt got=%0d exp=1", ver_err_cnt);
    end
    tick();
    ver_in_valid = 1'b1;
    ver_err_clr  = 1'b1;
    tick();
    ver_in_valid = 1'b0;
    ver_err_clr  = 1'b0;
    #1;
    checks++;
    if (ver_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_prio got=%0d exp=0", ver_err_cnt);
    end
    tick();
    tick();
  endtask

  task automatic test_multihot();
    logic [3:0] want;
    int         base;
    base          = exp_cnt;
    ver_out_ready = 1'b1;
    ver_in        = 8'h26;
    ver_in_valid  = 1'b1;
    tick();
    ver_in_valid  = 1'b0;
    #1;
`ifdef MVER_ENC_PRIO_EN
    want = {3'd5, 1'b0};
`else
    want = {3'd0, 1'b1};
    base = base + 1;
`endif
    checks++;
    if ({ver_out, ver_err} !== want || ver_err_cnt !== 8'(base)) begin
      failures++;
      $display("FAIL multihot got=%0d/%0b cnt=%0d exp=%0d/%0b cnt=%0d", ver_out, ver_err, ver_err_cnt, want[3:1], want[0], base);
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      ver_in_valid  = ($urandom_range(0, 3) != 0);
      ver_out_ready = ($urandom_range(0, 2) != 0);
      ver_err_clr   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) ver_in = 8'($urandom);
      else                           ver_in = 8'd1 << $urandom_range(0, 7);
      tick();
    end
    ver_in_valid  = 1'b0;
    ver_err_clr   = 1'b0;
    ver_out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    ver_out_ready = 1'b0;
    ver_in        = 8'h00;
    ver_in_valid  = 1'b1;
    tick();
    ver_in        = 8'h40;
    tick();
    ver_in_valid  = 1'b0;
    #2 ver_rst = 1'b1;
    #1;
    checks++;
    if (ver_out_valid !== 1'b0 || ver_err_cnt !== 8'd0 || ver_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=v%0b cnt=%0d r%0b exp=v0 cnt=0 r0", ver_out_valid, ver_err_cnt, ver_in_ready);
    end
    q.delete();
    exp_cnt   = 0;
    exp_ready = 1'b0;
    @(negedge ver_clk);
    ver_rst       = 1'b0;
    ver_out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_saturate();
    d2_in        = 8'h00;
    d2_in_valid  = 1'b1;
    d2_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (d2_in_ready !== 1'b1 || d2_err_cnt !== 2'((k > 3) ? 3 : k)) begin
        failures++;
        $display("FAIL sat_step%0d got=r%0b cnt=%0d exp=r1 cnt=%0d", k, d2_in_ready, d2_err_cnt, (k > 3) ? 3 : k);
      end
      tick();
    end
    d2_in_valid = 1'b0;
    #1;
    checks++;
    if (d2_err_cnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_final got=%0d exp=3", d2_err_cnt);
    end
    d2_err_clr = 1'b1;
    tick();
    d2_err_clr = 1'b0;
    #1;
    checks++;
    if (d2_err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL sat_clr got=%0d exp=0", d2_err_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_backpressure();
    test_errors();
    test_multihot();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
